cpu_seq_ctrl: RTL and testbench



---
 rtl/cpu_seq_ctrl_pkg.sv | 29 ++
 rtl/cpu_seq_ctrl_watchdog.sv | 38 +++
 rtl/cpu_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state and halt-cause
// encodings, the reset instruction word and the default boot address.
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_ILLEGAL  = 2'd1,
    HC_MISALIGN = 2'd2,
    HC_TIMEOUT  = 2'd3
  } halt_cause_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  function automatic logic target_misaligned(input logic [63:0] target);
    return target[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_watchdog.sv
// Fetch watchdog: counts cycles while enabled and flags the cycle in which the
// count reaches LIMIT; clear has priority and returns the count to zero.
module cpu_seq_ctrl_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires in the cycle whose increment would make the count equal LIMIT.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, runs the imem handshake, holds
// the instruction for decode/execute and gates the single writeback cycle.
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic        inst_valid,
  input  logic        ex_busy,
  input  logic        rd_w_ena_i,
  output logic        rd_w_ena_o,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        illegal_inst,
  output logic [63:0] pc,
  output logic        retire,
  output logic [63:0] retire_cnt,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  ctrl_state_e state_q, state_d;
  halt_cause_e cause_q, cause_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        wd_expire;

  // The watchdog only runs in WAIT; any other state or a returning rvalid clears it.
  cpu_seq_ctrl_watchdog #(
    .LIMIT (FETCH_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q != ST_WAIT) || imem_rvalid),
    .en_i     (state_q == ST_WAIT),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;
    inst_d       = inst_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_gnt && imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ST_DECODE;
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ST_DECODE;
        end else if (wd_expire) begin
          cause_d = HC_TIMEOUT;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (illegal_inst) begin
          cause_d = HC_ILLEGAL;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!ex_busy) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        // A misaligned redirect still retires the instruction but freezes the PC.
        retire_cnt_d = retire_cnt_q + 64'd1;
        if (branch_taken && target_misaligned(branch_target)) begin
          cause_d = HC_MISALIGN;
          state_d = ST_HALT;
        end else begin
          pc_d    = branch_taken ? branch_target : pc_q + 64'd4;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      cause_q      <= HC_NONE;
      pc_q         <= RESET_PC;
      retire_cnt_q <= '0;
      inst_q       <= NOP_INST;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
      inst_q       <= inst_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign inst_o     = inst_q;
  assign inst_valid = (state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB);
  assign rd_w_ena_o = (state_q == ST_WB) && rd_w_ena_i;
  assign retire     = (state_q == ST_WB);
  assign pc         = pc_q;
  assign retire_cnt = retire_cnt_q;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios plus randomized instruction streams
// checked against a per-instruction reference model of PC, count, latency and halt.
module tb_cpu_seq_ctrl;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        ex_busy;
  logic        rd_w_ena_i;
  logic        rd_w_ena_o;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        illegal_inst;
  logic [63:0] pc;
  logic        retire;
  logic [63:0] retire_cnt;
  logic        halted;
  logic [1:0]  halt_cause;

  int checks = 0;
  int passes = 0;

  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  logic        m_halt;
  logic [1:0]  m_cause;

  cpu_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_o(inst_o), .inst_valid(inst_valid), .ex_busy(ex_busy),
    .rd_w_ena_i(rd_w_ena_i), .rd_w_ena_o(rd_w_ena_o), .branch_taken(branch_taken),
    .branch_target(branch_target), .illegal_inst(illegal_inst), .pc(pc),
    .retire(retire), .retire_cnt(retire_cnt), .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic clear_inputs;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0; ex_busy = 0;
    rd_w_ena_i = 0; branch_taken = 0; branch_target = 64'h0; illegal_inst = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    m_pc = RPC; m_cnt = 64'd0; m_halt = 0; m_cause = 2'd0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || rd_w_ena_o !== 1'b0 || retire !== 1'b0 ||
        halted !== 1'b0 || halt_cause !== 2'd0 || pc !== RPC || imem_addr !== RPC ||
        inst_o !== NOP || retire_cnt !== 64'd0)
      $display("FAIL %s: req=%b iv=%b we=%b ret=%b hlt=%b cause=%0d pc=%h inst=%h cnt=%0d, expected all zero, pc=%h inst=%h",
               tag, imem_req, inst_valid, rd_w_ena_o, retire, halted, halt_cause, pc, inst_o,
               retire_cnt, RPC, NOP);
    else passes++;
  endtask

  // Runs one instruction through the handshake and compares against the model.
  task automatic do_instr(input int gdly, input int gap, input int busy, input logic rdw,
                          input logic tk, input logic [63:0] tgt, input logic ill,
                          input logic [31:0] word);
    int lat, k, w;
    logic seen;
    rd_w_ena_i = rdw; branch_taken = tk; branch_target = tgt;
    illegal_inst = 0; ex_busy = 0; imem_gnt = 0; imem_rvalid = 0;
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc)
      $display("FAIL fetch_addr: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, m_pc);
    else passes++;
    lat = 1;
    for (int i = 0; i < gdly; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk); lat++;
    end
    imem_rvalid = 0;
    checks++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0)
      $display("FAIL req_held: req=%b iv=%b, expected req=1 iv=0", imem_req, inst_valid);
    else passes++;
    imem_gnt = 1; imem_rvalid = (gap == 0); imem_rdata = word;
    @(negedge clk); lat++;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
    for (int i = 1; i <= gap; i++) begin
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0)
        $display("FAIL wait_idle: req=%b iv=%b hlt=%b, expected 0 0 0", imem_req, inst_valid, halted);
      else passes++;
      imem_rvalid = (i == gap);
      imem_rdata = (i == gap) ? word : $urandom;
      @(negedge clk); lat++;
      imem_rvalid = 0; imem_rdata = $urandom;
    end
    seen = 0; k = 0;
    while (!seen && halted !== 1'b1 && k < 40) begin
      illegal_inst = (k == 0) ? ill : 1'($urandom_range(0, 1));
      ex_busy = (k >= 1 && k <= busy) ? 1'b1 : ((k == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (k == 0) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_o !== word)
          $display("FAIL decode_inst: iv=%b inst=%h, expected iv=1 inst=%h", inst_valid, inst_o, word);
        else passes++;
      end
      if (retire === 1'b1) begin
        seen = 1;
        checks++;
        if (lat != 4 + gdly + gap + busy)
          $display("FAIL latency: got %0d cycles, expected %0d", lat, 4 + gdly + gap + busy);
        else passes++;
        checks++;
        if (rd_w_ena_o !== rdw || inst_o !== word || inst_valid !== 1'b1 || retire_cnt !== m_cnt)
          $display("FAIL wb_outputs: we=%b inst=%h iv=%b cnt=%0d, expected we=%b inst=%h iv=1 cnt=%0d",
                   rd_w_ena_o, inst_o, inst_valid, retire_cnt, rdw, word, m_cnt);
        else passes++;
      end else begin
        checks++;
        if (rd_w_ena_o !== 1'b0)
          $display("FAIL wena_gate: rd_w_ena_o=%b outside writeback, expected 0", rd_w_ena_o);
        else passes++;
      end
      @(negedge clk); lat++; k++;
    end
    illegal_inst = 0; ex_busy = 0;
    if (ill) begin
      m_halt = 1; m_cause = 2'd1;
    end else begin
      m_cnt = m_cnt + 64'd1;
      if (tk && tgt[1:0] != 2'b00) begin
        m_halt = 1; m_cause = 2'd2;
      end else begin
        m_pc = tk ? tgt : m_pc + 64'd4;
      end
    end
    checks++;
    if (seen !== !ill || halted !== m_halt || halt_cause !== m_cause || pc !== m_pc || retire_cnt !== m_cnt)
      $display("FAIL after_instr: retired=%b hlt=%b cause=%0d pc=%h cnt=%0d, expected %b %b %0d %h %0d",
               seen, halted, halt_cause, pc, retire_cnt, !ill, m_halt, m_cause, m_pc, m_cnt);
    else passes++;
  endtask

  task automatic check_halted_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom; rd_w_ena_i = 1; illegal_inst = 1'($urandom_range(0, 1));
      checks++;
      if (halted !== 1'b1 || halt_cause !== m_cause || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
          retire !== 1'b0 || rd_w_ena_o !== 1'b0 || pc !== m_pc || retire_cnt !== m_cnt)
        $display("FAIL halt_idle: hlt=%b cause=%0d req=%b iv=%b ret=%b we=%b pc=%h cnt=%0d, expected cause=%0d pc=%h cnt=%0d",
                 halted, halt_cause, imem_req, inst_valid, retire, rd_w_ena_o, pc, retire_cnt,
                 m_cause, m_pc, m_cnt);
      else passes++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    imem_rvalid = 1; imem_gnt = 1; imem_rdata = 32'hFFFF_FFFF; rd_w_ena_i = 1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 0; clear_inputs();
    m_pc = RPC; m_cnt = 64'd0; m_halt = 0; m_cause = 2'd0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL boot_cycle: req=%b iv=%b, expected 0 0", imem_req, inst_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC)
      $display("FAIL first_fetch: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RPC);
    else passes++;
    do_instr(0, 0, 0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0050_0093);
  endtask

  task automatic test_wait_busy;
    do_instr(0, 3, 2, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0010_8113);
    do_instr(2, 1, 0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0020_0193);
  endtask

  task automatic test_branch;
    do_instr(0, 0, 0, 1'b1, 1'b1, 64'h0000_0000_8000_0100, 1'b0, 32'h0000_0063);
    do_instr(1, 0, 1, 1'b1, 1'b1, 64'h0000_0000_8000_0102, 1'b0, 32'h0000_0463);
    check_halted_idle(5);
  endtask

  task automatic test_illegal;
    do_reset();
    do_instr(0, 0, 0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0030_0213);
    do_instr(0, 1, 0, 1'b1, 1'b0, 64'h0, 1'b1, 32'hFFFF_FFFF);
    check_halted_idle(5);
  endtask

  task automatic test_timeout;
    int w;
    do_reset();
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    imem_gnt = 1; @(negedge clk); imem_gnt = 0;
    for (int i = 1; i <= TO; i++) begin
      checks++;
      if (halted !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL timeout_wait%0d: hlt=%b req=%b, expected 0 0", i, halted, imem_req);
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd3)
      $display("FAIL timeout_halt: hlt=%b cause=%0d, expected 1 3", halted, halt_cause);
    else passes++;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 0;
    checks++;
    if (inst_o !== NOP || inst_valid !== 1'b0)
      $display("FAIL late_rvalid: inst=%h iv=%b, expected %h 0", inst_o, inst_valid, NOP);
    else passes++;
    m_halt = 1; m_cause = 2'd3;
    check_halted_idle(3);
    do_reset();
    do_instr(0, 0, 0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0000_0013);
  endtask

  task automatic test_reset_mid;
    int w;
    do_instr(0, 0, 0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0040_0293);
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h1234_5678; rd_w_ena_i = 1;
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0; ex_busy = 1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h1234_5678)
      $display("FAIL mid_exec: iv=%b inst=%h, expected 1 12345678", inst_valid, inst_o);
    else passes++;
    rst = 1;
    @(negedge clk);
    check_reset_values("reset_mid_exec");
    rst = 0; ex_busy = 0;
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    m_pc = RPC; m_cnt = 64'd0; m_halt = 0; m_cause = 2'd0;
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0;
    checks++;
    if (inst_o !== NOP || imem_req !== 1'b1 || imem_addr !== RPC || retire_cnt !== 64'd0)
      $display("FAIL stale_rvalid: inst=%h req=%b addr=%h cnt=%0d, expected %h 1 %h 0",
               inst_o, imem_req, imem_addr, retire_cnt, NOP, RPC);
    else passes++;
    do_instr(0, 0, 0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0060_0313);
  endtask

  task automatic test_random;
    logic        tk;
    logic [63:0] tgt;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      tk = 1'($urandom_range(0, 2) == 0);
      tgt = {$urandom, $urandom} & ~64'h3;
      if (n == 10) begin tk = 1; tgt = 64'hFFFF_FFFF_FFFF_FFFC; end
      if (n == 11) tk = 0;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), tk, tgt, 1'b0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_wait_busy();
    test_branch();
    test_illegal();
    test_timeout();
    do_reset();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
